sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 Parameters SHALL be, one per line:
- ROW_WIDTH, 13, row address bits.
- COL_WIDTH, 9, column address bits.
- BANK_WIDTH, 2, bank bits.
- MEM_AW, 10, backing-store word-address bits; store index = low MEM_AW bits of {bank, row, col}.
REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- clock_enable  in  1  CKE; commands are ignored when 0.
- cs_n, ras_n, cas_n, we_n  in  1 each  command strobes.
- addr  in  13  row, column or mode address.
- bank_addr  in  2  bank select.
- data_in  in  16  write data from the controller.
- data_oe  in  1  controller drives write data.
- data_mask_low, data_mask_high  in  1 each  byte masks; 1 = lane masked.
- data_out  out  16  read data.
- data_out_valid  out  1  data_out is valid this cycle.
- init_done  out  1  init sequence complete.
- ref_count  out  16  REF commands accepted after init.
- err  out  5  sticky protocol-error flags.

Function
REQ-003 Commands SHALL be decoded on each posedge when clock_enable=1 and cs_n=0, using {ras_n,cas_n,we_n}: 111 NOP, 011 ACT, 101 READ, 100 WRITE, 010 PRE, 001 REF, 000 MRS; cs_n=1 SHALL be treated as NOP.
REQ-004 Init FSM states SHALL be W_PALL -> W_REF1 -> W_REF2 -> W_MRS -> READY:
- PRE with addr[10]=1 SHALL advance W_PALL.
- Each REF SHALL advance one REF state.
- MRS SHALL enter READY and assert init_done on the next cycle.
- Any other non-NOP command before READY SHALL be ignored and set err[0].
REQ-005 MRS SHALL latch CAS latency from addr[6:4]; only values 2 and 3 SHALL be legal, and any other value SHALL select 3 and set err[1].
REQ-006 Each bank SHALL keep an open flag and a row register.
- ACT SHALL open the bank and latch addr as the row.
- PRE SHALL close bank_addr; PRE with addr[10]=1 SHALL close all banks.
REQ-007 WRITE to an open bank SHALL write data_in into the store at the same edge, with per-byte enables: low byte when data_mask_low=0, high byte when data_mask_high=0.
REQ-008 READ to an open bank SHALL present the stored word on data_out, with data_out_valid=1 for exactly one cycle, CL cycles after the READ edge (CL=3: valid during the 3rd cycle after).
REQ-009 The read pipeline SHALL accept a new READ every cycle without loss; overlapping returns SHALL emerge in issue order.
REQ-010 READ or WRITE with addr[10]=1 SHALL close the bank after the access (auto-precharge).
REQ-011 REF with all banks closed SHALL increment ref_count, which SHALL wrap from 0xFFFF to 0.
REQ-012 Protocol errors SHALL set sticky err bits; the offending command SHALL have no effect except that set:
- err[2]: READ or WRITE to a closed bank.
- err[3]: ACT to an open bank.
- err[4]: REF with any bank open, or data_oe=1 on a cycle that is not a WRITE.
REQ-013 When data_out_valid=0, data_out SHALL be 0.

Reset
REQ-014 While rst_n=0, the following SHALL hold: init FSM = W_PALL, all banks closed, CL=3, read pipeline flushed, data_out=0, data_out_valid=0, init_done=0, ref_count=0, err=0.
REQ-015 Reset asserted mid-read SHALL discard the pending return; no data_out_valid SHALL follow.
REQ-016 Store contents SHALL NOT be reset.

Configuration
REQ-017 With SDRAM_RESP_CHECK_EN defined, err SHALL be generated per REQ-004/005/012.
REQ-018 Without SDRAM_RESP_CHECK_EN, err SHALL be constant 0. Illegal commands SHALL still be dropped, and illegal CL SHALL still select 3.

Structure
REQ-019 Command encodings, init-state encodings and the default CL SHALL live in shared package sdram_pkg, used also by the controller bench.
REQ-020 The backing store SHALL be the sub-module sdram_resp_mem: 2^MEM_AW x 16, byte-write enables, synchronous write, registered read.

Verification
REQ-021 Init: PALL(addr[10]=1), REF, REF, MRS addr=0x030 -> init_done=1 one cycle after MRS, CL=3, err=0.
REQ-022 Write/read: ACT bank1 row 0x005; WRITE col 0x012, data 0xA5C3, masks 00; READ col 0x012 -> data_out=0xA5C3, valid exactly 3 cycles after READ.
REQ-023 Byte mask: write 0x1234 with data_mask_high=1 over a stored 0xFFFF, then read -> 0xFF34.
REQ-024 Errors: READ to a closed bank -> err[2]=1, no valid pulse; ACT to an open bank -> err[3]=1; both remain set until reset.
REQ-025 Refresh: 65536 legal REFs after init -> ref_count wraps to 0; REF with bank 0 open -> err[4]=1, count unchanged.
REQ-026 Reset 1 cycle after READ (CL=3) -> data_out_valid stays 0; init_done=0.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM command and init-sequence encodings, used by the responder model
// and by the controller bench.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_MRS   = 3'b000,
    CMD_REF   = 3'b001,
    CMD_PRE   = 3'b010,
    CMD_ACT   = 3'b011,
    CMD_WRITE = 3'b100,
    CMD_READ  = 3'b101,
    CMD_BST   = 3'b110,
    CMD_NOP   = 3'b111
  } cmd_e;

  typedef enum logic [2:0] {
    W_PALL = 3'd0,
    W_REF1 = 3'd1,
    W_REF2 = 3'd2,
    W_MRS  = 3'd3,
    READY  = 3'd4
  } init_state_e;

  localparam logic [2:0] CL_DEFAULT = 3'd3;

endpackage

// File: rtl/sdram_resp_mem.sv
// Backing store for the SDRAM responder: 2^AW x 16, byte-write enables,
// synchronous write and registered read. Contents are deliberately not reset.
module sdram_resp_mem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [1:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] store [2**AW];

  always_ff @(posedge clk) begin
    if (we && be[0]) store[addr][7:0]  <= wdata[7:0];
    if (we && be[1]) store[addr][15:8] <= wdata[15:8];
    if (re)          rdata             <= store[addr];
  end

endmodule

// File: rtl/sdram_responder.sv
// Behavioural SDRAM device responder: init FSM, per-bank open rows, CL 2/3 read
// return, refresh counting. Define SDRAM_RESP_CHECK_EN to generate sticky err flags.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int ROW_WIDTH  = 13,
  parameter int COL_WIDTH  = 9,
  parameter int BANK_WIDTH = 2,
  parameter int MEM_AW     = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clock_enable,
  input  logic                  cs_n,
  input  logic                  ras_n,
  input  logic                  cas_n,
  input  logic                  we_n,
  input  logic [ROW_WIDTH-1:0]  addr,
  input  logic [BANK_WIDTH-1:0] bank_addr,
  input  logic [15:0]           data_in,
  input  logic                  data_oe,
  input  logic                  data_mask_low,
  input  logic                  data_mask_high,
  output logic [15:0]           data_out,
  output logic                  data_out_valid,
  output logic                  init_done,
  output logic [15:0]           ref_count,
  output logic [4:0]            err
);

  localparam int NBANK = 1 << BANK_WIDTH;
  localparam int IDX_W = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

  cmd_e                 cmd;
  init_state_e          state_q, state_d;
  logic                 ready;
  logic [NBANK-1:0]     open_q;
  logic [ROW_WIDTH-1:0] row_q [NBANK];
  logic [2:0]           cl_q;
  logic                 bank_open, any_open, is_rw, rw_closed, act_open, ref_open, mrs_ok;
  logic                 mem_we, mem_re;
  logic [IDX_W-1:0]     full_idx;
  logic                 unused_idx;
  logic [15:0]          mem_rdata;
  logic                 rd_v0, rd_v1, rd_v2;
  logic [15:0]          rd_d1, rd_d2;

  always_comb begin
    cmd = CMD_NOP;
    if (clock_enable && !cs_n) cmd = cmd_e'({ras_n, cas_n, we_n});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= W_PALL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_PALL:  if (cmd == CMD_PRE && addr[10]) state_d = W_REF1;
      W_REF1:  if (cmd == CMD_REF)             state_d = W_REF2;
      W_REF2:  if (cmd == CMD_REF)             state_d = W_MRS;
      W_MRS:   if (cmd == CMD_MRS)             state_d = READY;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    ready     = (state_q == READY);
    init_done = ready;
  end

  assign bank_open = open_q[bank_addr];
  assign any_open  = |open_q;
  assign is_rw     = ready && (cmd == CMD_READ || cmd == CMD_WRITE);
  assign rw_closed = is_rw && !bank_open;
  assign act_open  = ready && cmd == CMD_ACT && bank_open;
  assign ref_open  = ready && cmd == CMD_REF && any_open;
  assign mrs_ok    = cmd == CMD_MRS && (ready || state_q == W_MRS);
  assign mem_we    = is_rw && bank_open && cmd == CMD_WRITE;
  assign mem_re    = is_rw && bank_open && cmd == CMD_READ;

  // Only the low MEM_AW bits address the store; upper row/bank bits alias.
  assign full_idx   = {bank_addr, row_q[bank_addr], addr[COL_WIDTH-1:0]};
  assign unused_idx = ^full_idx[IDX_W-1:MEM_AW];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q    <= '0;
      ref_count <= '0;
      cl_q      <= CL_DEFAULT;
      for (int i = 0; i < NBANK; i++) row_q[i] <= '0;
    end else begin
      if (mrs_ok) cl_q <= (addr[6:4] == 3'd2) ? 3'd2 : CL_DEFAULT;
      if (ready) begin
        case (cmd)
          CMD_ACT: if (!bank_open) begin
            open_q[bank_addr] <= 1'b1;
            row_q[bank_addr]  <= addr;
          end
          CMD_PRE: if (addr[10]) open_q <= '0;
                   else          open_q[bank_addr] <= 1'b0;
          CMD_READ, CMD_WRITE: if (bank_open && addr[10]) open_q[bank_addr] <= 1'b0;
          CMD_REF: if (!any_open) ref_count <= ref_count + 16'd1;
          default: ;
        endcase
      end
    end
  end

  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .be    ({~data_mask_high, ~data_mask_low}),
    .addr  (full_idx[MEM_AW-1:0]),
    .wdata (data_in),
    .rdata (mem_rdata)
  );

  // The store's registered read is stage 0; the output register adds the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_v0          <= 1'b0;
      rd_v1          <= 1'b0;
      rd_v2          <= 1'b0;
      rd_d1          <= '0;
      rd_d2          <= '0;
      data_out_valid <= 1'b0;
      data_out       <= '0;
    end else begin
      rd_v0 <= mem_re;
      rd_v1 <= rd_v0;
      rd_d1 <= mem_rdata;
      rd_v2 <= rd_v1;
      rd_d2 <= rd_d1;
      if (cl_q == 3'd2) begin
        data_out_valid <= rd_v1;
        data_out       <= rd_v1 ? rd_d1 : 16'd0;
      end else begin
        data_out_valid <= rd_v2;
        data_out       <= rd_v2 ? rd_d2 : 16'd0;
      end
    end
  end

`ifdef SDRAM_RESP_CHECK_EN
  logic       init_bad, cl_bad, oe_bad;
  logic [4:0] err_q;

  assign init_bad = !ready && cmd != CMD_NOP && state_d == state_q;
  assign cl_bad   = mrs_ok && addr[6:4] != 3'd2 && addr[6:4] != 3'd3;
  assign oe_bad   = data_oe && cmd != CMD_WRITE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else        err_q <= err_q | {ref_open | oe_bad, act_open, rw_closed, cl_bad, init_bad};
  end

  assign err = err_q;
`else
  logic unused_oe;
  assign unused_oe = data_oe;
  assign err       = '0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder: init, write/read with masks,
// back-to-back reads, auto-precharge, protocol errors, refresh wrap, reset mid-read.
module tb_sdram_responder;
  import sdram_pkg::*;

`ifdef SDRAM_RESP_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clock_enable = 1'b1;
  logic        cs_n = 1'b1, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
  logic [12:0] addr = '0;
  logic [1:0]  bank_addr = '0;
  logic [15:0] data_in = '0;
  logic        data_oe = 1'b0;
  logic        data_mask_low = 1'b0, data_mask_high = 1'b0;
  logic [15:0] data_out;
  logic        data_out_valid;
  logic        init_done;
  logic [15:0] ref_count;
  logic [4:0]  err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdram_responder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clock_enable   (clock_enable),
    .cs_n           (cs_n),
    .ras_n          (ras_n),
    .cas_n          (cas_n),
    .we_n           (we_n),
    .addr           (addr),
    .bank_addr      (bank_addr),
    .data_in        (data_in),
    .data_oe        (data_oe),
    .data_mask_low  (data_mask_low),
    .data_mask_high (data_mask_high),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .init_done      (init_done),
    .ref_count      (ref_count),
    .err            (err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_err(input logic [4:0] e);
    return CHK ? e : 5'd0;
  endfunction

  // Drive one command for one clock; returns 1 time unit after the sampling edge.
  task automatic issue(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a);
    @(negedge clk);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = c; bank_addr = b; addr = a;
    @(posedge clk); #1;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = CMD_NOP;
  endtask

  task automatic write(input logic [1:0] b, input logic [12:0] a, input logic [15:0] d,
                       input logic mh, input logic ml);
    @(negedge clk);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = CMD_WRITE; bank_addr = b; addr = a;
    data_in = d; data_oe = 1'b1; data_mask_high = mh; data_mask_low = ml;
    @(posedge clk); #1;
    cs_n = 1'b1; {ras_n, cas_n, we_n} = CMD_NOP; data_oe = 1'b0;
    data_mask_high = 1'b0; data_mask_low = 1'b0;
  endtask

  task automatic expect_read(input string tag, input logic [15:0] exp, input int cl);
    for (int k = 1; k <= cl + 1; k++) begin
      @(posedge clk); #1;
      check_eq({tag, "_valid"}, 32'(data_out_valid), (k == cl) ? 32'd1 : 32'd0);
      check_eq({tag, "_data"}, 32'(data_out), (k == cl) ? 32'(exp) : 32'd0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      seen = seen | data_out_valid;
    end
    check_eq({tag, "_novalid"}, 32'(seen), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_init_done", 32'(init_done), 32'd0);
    check_eq("rst_valid", 32'(data_out_valid), 32'd0);
    check_eq("rst_data", 32'(data_out), 32'd0);
    check_eq("rst_ref_count", 32'(ref_count), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Init sequence, CL=3
    issue(CMD_PRE, 2'd0, 13'h400);
    issue(CMD_REF, 2'd0, 13'h000);
    issue(CMD_REF, 2'd0, 13'h000);
    check_eq("init_before_mrs", 32'(init_done), 32'd0);
    issue(CMD_MRS, 2'd0, 13'h030);
    check_eq("init_done", 32'(init_done), 32'd1);
    check_eq("init_err", 32'(err), 32'd0);

    // Write/read bank1 row 5 col 0x012
    issue(CMD_ACT, 2'd1, 13'h005);
    write(2'd1, 13'h012, 16'hA5C3, 1'b0, 1'b0);
    issue(CMD_READ, 2'd1, 13'h012);
    expect_read("rd_a5c3", 16'hA5C3, 3);

    // Byte masks over 0xFFFF at col 0x020
    write(2'd1, 13'h020, 16'hFFFF, 1'b0, 1'b0);
    write(2'd1, 13'h020, 16'h1234, 1'b1, 1'b0);
    issue(CMD_READ, 2'd1, 13'h020);
    expect_read("rd_mask_hi", 16'hFF34, 3);
    write(2'd1, 13'h020, 16'h5678, 1'b0, 1'b1);
    issue(CMD_READ, 2'd1, 13'h020);
    expect_read("rd_mask_lo", 16'h5634, 3);

    // Back-to-back reads return in order
    issue(CMD_READ, 2'd1, 13'h012);
    issue(CMD_READ, 2'd1, 13'h020);
    @(posedge clk); #1;
    check_eq("b2b_e2_valid", 32'(data_out_valid), 32'd0);
    @(posedge clk); #1;
    check_eq("b2b_first_valid", 32'(data_out_valid), 32'd1);
    check_eq("b2b_first_data", 32'(data_out), 32'hA5C3);
    @(posedge clk); #1;
    check_eq("b2b_second_valid", 32'(data_out_valid), 32'd1);
    check_eq("b2b_second_data", 32'(data_out), 32'h5634);
    @(posedge clk); #1;
    check_eq("b2b_after_valid", 32'(data_out_valid), 32'd0);

    // Auto-precharge read closes bank1; a following read is a closed-bank error
    issue(CMD_READ, 2'd1, 13'h412);
    expect_read("rd_autopre", 16'hA5C3, 3);
    issue(CMD_READ, 2'd1, 13'h012);
    expect_quiet("rd_closed", 5);
    check_eq("err_closed", 32'(err), 32'(exp_err(5'b00100)));

    issue(CMD_ACT, 2'd1, 13'h005);
    issue(CMD_ACT, 2'd1, 13'h005);
    check_eq("err_act_open", 32'(err), 32'(exp_err(5'b01100)));
    issue(CMD_REF, 2'd0, 13'h000);
    check_eq("err_ref_open", 32'(err), 32'(exp_err(5'b11100)));
    check_eq("ref_open_count", 32'(ref_count), 32'd0);

    // Refresh counting and wrap
    issue(CMD_PRE, 2'd0, 13'h400);
    issue(CMD_REF, 2'd0, 13'h000);
    check_eq("ref_count_1", 32'(ref_count), 32'd1);
    @(negedge clk);
    cs_n = 1'b0; {ras_n, cas_n, we_n} = CMD_REF;
    repeat (65534) @(posedge clk);
    #1;
    check_eq("ref_count_ffff", 32'(ref_count), 32'hFFFF);
    @(posedge clk); #1;
    check_eq("ref_count_wrap", 32'(ref_count), 32'd0);
    cs_n = 1'b1; {ras_n, cas_n, we_n} = CMD_NOP;
    check_eq("err_sticky", 32'(err), 32'(exp_err(5'b11100)));

    // Reset one cycle after a READ discards the return
    issue(CMD_ACT, 2'd2, 13'h000);
    issue(CMD_READ, 2'd2, 13'h000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("midrst_valid", 32'(data_out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    expect_quiet("midrst", 4);
    check_eq("midrst_init_done", 32'(init_done), 32'd0);
    check_eq("midrst_err", 32'(err), 32'd0);
    check_eq("midrst_ref_count", 32'(ref_count), 32'd0);

    // Illegal command during init is dropped; re-init with CL=2
    issue(CMD_ACT, 2'd0, 13'h000);
    issue(CMD_PRE, 2'd0, 13'h400);
    issue(CMD_REF, 2'd0, 13'h000);
    issue(CMD_REF, 2'd0, 13'h000);
    issue(CMD_MRS, 2'd0, 13'h020);
    check_eq("reinit_done", 32'(init_done), 32'd1);
    check_eq("err_init_cmd", 32'(err), 32'(exp_err(5'b00001)));

    // Bank 3 row 1 aliases store index 0x212; contents survive reset
    issue(CMD_ACT, 2'd3, 13'h001);
    issue(CMD_READ, 2'd3, 13'h012);
    expect_read("rd_cl2", 16'hA5C3, 2);

    // Illegal CL selects 3
    issue(CMD_MRS, 2'd0, 13'h050);
    check_eq("err_bad_cl", 32'(err), 32'(exp_err(5'b00011)));
    issue(CMD_READ, 2'd3, 13'h020);
    expect_read("rd_bad_cl", 16'h5634, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
